// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stall/flush controller.
//   STATE_W       : width of the stall-controller FSM state
//   RUN/MEM_WAIT/HALT : FSM state encodings
//   stall_ctrl_t  : bundle of pipeline-register freeze/flush/bubble controls
//   stall_ctrl_for: priority resolution mem_stall > branch > hazard
package mips_pipe_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] RUN      = 2'd0;
  localparam logic [STATE_W-1:0] MEM_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] HALT     = 2'd2;

  typedef struct packed {
    logic pc_freeze;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_exe_bubble;
    logic exe_mem_freeze;
    logic mem_wb_bubble;
  } stall_ctrl_t;

  // Resolve the three stall sources into one control set; memory wins because
  // a frozen EXE keeps branch_taken valid until the access completes.
  function automatic stall_ctrl_t stall_ctrl_for(input logic mem_stall,
                                                 input logic branch_taken,
                                                 input logic hazard_detected);
    stall_ctrl_t c;
    c = '0;
    if (mem_stall) begin
      c.pc_freeze      = 1'b1;
      c.if_id_freeze   = 1'b1;
      c.exe_mem_freeze = 1'b1;
      c.mem_wb_bubble  = 1'b1;
    end else if (branch_taken) begin
      // Hazard on a squashed instruction is irrelevant; PC must load the target.
      c.if_id_flush   = 1'b1;
      c.id_exe_bubble = 1'b1;
    end else if (hazard_detected) begin
      c.pc_freeze     = 1'b1;
      c.if_id_freeze  = 1'b1;
      c.id_exe_bubble = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk : clock
//   rst : synchronous active-high reset to zero
//   inc : count this cycle
//   q   : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush controller for the 5-stage pipeline.
//   clk, rst          : clock, synchronous active-high reset
//   hazard_detected   : load-use/RAW hazard in ID
//   branch_taken      : taken branch resolved in EXE
//   mem_req, mem_ready: MEM-stage data-memory handshake
//   pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble,
//   exe_mem_freeze, mem_wb_bubble : Mealy pipeline controls
//   mem_timeout       : sticky, set when the memory wait times out (HALT)
//   stall_cnt         : saturating count of hazard stalls applied
//   flush_cnt         : saturating count of branch flushes applied
//   state_dbg         : current FSM state
module pipeline_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard_detected,
  input  logic               branch_taken,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               pc_freeze,
  output logic               if_id_freeze,
  output logic               if_id_flush,
  output logic               id_exe_bubble,
  output logic               exe_mem_freeze,
  output logic               mem_wb_bubble,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [STATE_W-1:0] state_dbg
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic               mem_stall_c;
  logic               stall_inc_c;
  logic               flush_inc_c;
  stall_ctrl_t        ctrl_c;

  // Memory stall covers both an outstanding access and a halted pipeline.
  always_comb begin
    mem_stall_c = (mem_req & ~mem_ready) | (state_q == HALT);
  end

  // Mealy controls; forced quiet while reset is held.
  always_comb begin
    ctrl_c = '0;
    if (!rst) begin
      ctrl_c = stall_ctrl_for(mem_stall_c, branch_taken, hazard_detected);
    end
  end

  // Counter events: only the action that actually won priority is counted.
  always_comb begin
    stall_inc_c = 1'b0;
    flush_inc_c = 1'b0;
    if (!rst && (state_q != HALT) && !mem_stall_c) begin
      flush_inc_c = branch_taken;
      stall_inc_c = ~branch_taken & hazard_detected;
    end
  end

  // Memory-wait FSM next state.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        // An access that completes in its first cycle never leaves RUN.
        if (mem_req && !mem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        // A dropped request is treated as completed.
        if (!mem_req || mem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc_c),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc_c),
    .q   (flush_cnt)
  );

  // Output mapping.
  always_comb begin
    pc_freeze      = ctrl_c.pc_freeze;
    if_id_freeze   = ctrl_c.if_id_freeze;
    if_id_flush    = ctrl_c.if_id_flush;
    id_exe_bubble  = ctrl_c.id_exe_bubble;
    exe_mem_freeze = ctrl_c.exe_mem_freeze;
    mem_wb_bubble  = ctrl_c.mem_wb_bubble;
    mem_timeout    = timeout_q & ~rst;
    state_dbg      = state_q;
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl (MEM_TIMEOUT=4, CNT_W=2).
module tb_pipeline_stall_ctrl;

  localparam int unsigned MT    = 4;
  localparam int unsigned CW    = 2;
  localparam int          CMAX  = (1 << CW) - 1;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_HAZ  = 6'b110100;
  localparam logic [5:0] C_BR   = 6'b001100;
  localparam logic [5:0] C_MEM  = 6'b110011;

  logic clk = 1'b0;
  logic rst, hazard_detected, branch_taken, mem_req, mem_ready;
  logic pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble;
  logic exe_mem_freeze, mem_wb_bubble, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0=running, 1=waiting on memory, 2=halted.
  int m_mode, m_waited, m_stalls, m_flushes;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_freeze       (pc_freeze),
    .if_id_freeze    (if_id_freeze),
    .if_id_flush     (if_id_flush),
    .id_exe_bubble   (id_exe_bubble),
    .exe_mem_freeze  (exe_mem_freeze),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .state_dbg       (state_dbg)
  );

  function automatic logic [5:0] act_ctrl();
    return {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, exe_mem_freeze, mem_wb_bubble};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected controls from the stated priority rules.
  function automatic logic [5:0] model_ctrl();
    if (rst) return C_NONE;
    if ((mem_req && !mem_ready) || m_mode == 2) return C_MEM;
    if (branch_taken) return C_BR;
    if (hazard_detected) return C_HAZ;
    return C_NONE;
  endfunction

  task automatic model_check();
    chk("ctrl", 32'(act_ctrl()), 32'(model_ctrl()));
    chk("mem_timeout", 32'(mem_timeout), (!rst && m_mode == 2) ? 32'd1 : 32'd0);
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
    chk("state_dbg", 32'(state_dbg), 32'(m_mode));
  endtask

  task automatic model_update();
    bit stalled;
    if (rst) begin
      m_mode = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
      return;
    end
    stalled = (mem_req && !mem_ready) || m_mode == 2;
    if (!stalled) begin
      if (branch_taken) m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
      else if (hazard_detected) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
    end
    if (m_mode == 0) begin
      if (mem_req && !mem_ready) begin m_mode = 1; m_waited = 1; end
    end else if (m_mode == 1) begin
      if (!mem_req || mem_ready) begin m_mode = 0; m_waited = 0; end
      else if (m_waited == MT - 1) m_mode = 2;
      else m_waited++;
    end
  endtask

  // Drive one cycle's inputs and stop at the negedge with the model checked.
  task automatic cyc(input bit hz, input bit br, input bit mr, input bit rdy, input bit rs);
    hazard_detected = hz; branch_taken = br; mem_req = mr; mem_ready = rdy; rst = rs;
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1, 1, 1, 0, 1);
    chk("rst_ctrl", 32'(act_ctrl()), 32'(C_NONE));
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    adv();
  endtask

  typedef struct {
    bit hz, br, mr, rdy;
    logic [5:0] ctrl;
    int st, sc, fc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    m_mode = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
    rst = 1; hazard_detected = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
    @(posedge clk); #1;
    model_update();
    do_reset();
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);

    // Table: inputs, expected controls, state and counters seen in that cycle.
    tbl[0]  = '{0, 0, 0, 0, C_NONE, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, C_HAZ,  0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, C_NONE, 0, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, C_BR,   0, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, C_NONE, 0, 1, 1};
    tbl[5]  = '{0, 0, 1, 1, C_NONE, 0, 1, 1};
    tbl[6]  = '{0, 0, 0, 0, C_NONE, 0, 1, 1};
    tbl[7]  = '{1, 0, 1, 0, C_MEM,  0, 1, 1};
    tbl[8]  = '{0, 1, 1, 0, C_MEM,  1, 1, 1};
    tbl[9]  = '{1, 0, 0, 0, C_HAZ,  1, 1, 1};
    tbl[10] = '{0, 0, 0, 0, C_NONE, 0, 2, 1};
    tbl[11] = '{0, 1, 0, 0, C_BR,   0, 2, 1};
    tbl[12] = '{0, 0, 0, 0, C_NONE, 0, 2, 2};
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].hz, tbl[i].br, tbl[i].mr, tbl[i].rdy, 0);
      chk($sformatf("tbl%0d_ctrl", i), 32'(act_ctrl()), 32'(tbl[i].ctrl));
      chk($sformatf("tbl%0d_state", i), 32'(state_dbg), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].sc));
      chk($sformatf("tbl%0d_flush", i), 32'(flush_cnt), 32'(tbl[i].fc));
      adv();
    end

    // Branch held across a 3-cycle memory wait, then released with mem_ready.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 0);
      chk("memwait_ctrl", 32'(act_ctrl()), 32'(C_MEM));
      chk("memwait_state", 32'(state_dbg), (i == 0) ? 32'd0 : 32'd1);
      adv();
    end
    cyc(0, 1, 1, 1, 0);
    chk("memdone_ctrl", 32'(act_ctrl()), 32'(C_BR));
    chk("memdone_flush_cnt", 32'(flush_cnt), 32'd0);
    adv();
    cyc(0, 0, 0, 0, 0);
    chk("after_mem_state", 32'(state_dbg), 32'd0);
    chk("after_mem_flush_cnt", 32'(flush_cnt), 32'd1);
    adv();

    // Timeout: four unanswered wait cycles, then HALT until reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("pre_halt_timeout", 32'(mem_timeout), 32'd0);
      adv();
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 0, 0);
      chk("halt_state", 32'(state_dbg), 32'd2);
      chk("halt_timeout", 32'(mem_timeout), 32'd1);
      chk("halt_ctrl", 32'(act_ctrl()), 32'(C_MEM));
      adv();
    end
    cyc(0, 0, 0, 0, 1);
    chk("halt_rst_ctrl", 32'(act_ctrl()), 32'(C_NONE));
    chk("halt_rst_timeout", 32'(mem_timeout), 32'd0);
    adv();
    cyc(0, 0, 0, 0, 0);
    chk("post_halt_state", 32'(state_dbg), 32'd0);
    chk("post_halt_ctrl", 32'(act_ctrl()), 32'(C_NONE));
    adv();

    // Saturation: hazard held for six cycles on a 2-bit counter.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0, 0);
      adv();
      chk($sformatf("sat_stall_%0d", i), 32'(stall_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 2);
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
